// File: rtl/count_up_down_mod.sv
// count_up_down_mod: parametrised up/down counter with load, enable and a wrap/saturate select.
// Define COUNT_OVF_STICKY_EN to enable the sticky overflow flag; otherwise ovf_sticky is tied low.
module count_up_down_mod #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}},
  parameter int unsigned      STEP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  out,
  output logic              tc,
  output logic              wrap,
  output logic              ovf_sticky
);

  localparam logic [WIDTH:0] MOD_P1 = {1'b0, MOD_MAX} + 1'b1;

  // Returns {boundary, next count}; one guard bit keeps the sum free of overflow.
  function automatic logic [WIDTH:0] count_next(
    input logic [WIDTH-1:0]  cur,
    input logic [STEP_W-1:0] stp,
    input logic              dir,
    input logic              sat
  );
    logic [WIDTH:0]   cur_x;
    logic [WIDTH:0]   stp_x;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt;
    logic             bnd;
    cur_x = {1'b0, cur};
    stp_x = (WIDTH+1)'(stp);
    nxt   = cur;
    bnd   = 1'b0;
    if (dir) begin
      sum = cur_x + stp_x;
      if (sum <= {1'b0, MOD_MAX}) begin
        nxt = sum[WIDTH-1:0];
      end else begin
        bnd = 1'b1;
        nxt = sat ? MOD_MAX : WIDTH'(sum - MOD_P1);
      end
    end else begin
      sum = cur_x + MOD_P1 - stp_x;
      if (stp_x <= cur_x) begin
        nxt = WIDTH'(cur_x - stp_x);
      end else begin
        bnd = 1'b1;
        nxt = sat ? '0 : sum[WIDTH-1:0];
      end
    end
    return {bnd, nxt};
  endfunction

  function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] v);
    return (v > MOD_MAX) ? MOD_MAX : v;
  endfunction

  // Stage p0: next-state decode from the current count and this cycle's controls
  logic [WIDTH:0] nxt_p0;
  logic           bnd_p0;

  assign nxt_p0 = count_next(out, step, up_down, sat_mode);
  assign bnd_p0 = en & ~load & nxt_p0[WIDTH];

  // Stage p1: registered count and wrap pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= bnd_p0 & ~sat_mode;
      if (load) begin
        out <= load_clamp(load_val);
      end else if (en) begin
        out <= nxt_p0[WIDTH-1:0];
      end
    end
  end

  assign tc = up_down ? (out == MOD_MAX) : (out == '0);

`ifdef COUNT_OVF_STICKY_EN
  // A boundary hit on the same edge as a clear keeps the flag set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_sticky <= 1'b0;
    end else if (bnd_p0) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_count_up_down_mod.sv
// Randomised and directed bench for count_up_down_mod: a default 8-bit counter and a
// decade (0..9) counter share stimulus and are checked against an integer reference model.
module tb_count_up_down_mod;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic       up_down;
  logic       sat_mode;
  logic       clr_ovf;
  logic [7:0] lv8;
  logic [3:0] lv9;
  logic [3:0] stp8;
  logic [2:0] stp9;
  logic [7:0] out8;
  logic [3:0] out9;
  logic       tc8, tc9, wrap8, wrap9, ovf8, ovf9;

  int n_cmp;
  int n_bad;

  // reference model state
  int c8, c9;
  bit w8, w9, o8, o9;

  assign stp9 = stp8[2:0];

  count_up_down_mod u_dut8 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv8),
    .up_down(up_down), .step(stp8), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .out(out8), .tc(tc8), .wrap(wrap8), .ovf_sticky(ovf8)
  );

  count_up_down_mod #(.WIDTH(4), .MOD_MAX(4'd9), .STEP_W(3)) u_dut9 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv9),
    .up_down(up_down), .step(stp9), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
    .out(out9), .tc(tc9), .wrap(wrap9), .ovf_sticky(ovf9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Counter over 0..M: wrap mode is arithmetic modulo M+1, saturate mode clamps to the end.
  task automatic model_step(input int M, input int s, input int lv,
                            inout int cnt, inout bit w, inout bit o);
    bit b;
    b = 1'b0;
    w = 1'b0;
    if (load) begin
      cnt = (lv > M) ? M : lv;
    end else if (en && s != 0) begin
      if (up_down) begin
        if (cnt + s > M) begin
          b = 1'b1;
          if (sat_mode) cnt = M;
          else begin cnt = (cnt + s) % (M + 1); w = 1'b1; end
        end else cnt = cnt + s;
      end else begin
        if (s > cnt) begin
          b = 1'b1;
          if (sat_mode) cnt = 0;
          else begin cnt = (cnt - s + M + 1) % (M + 1); w = 1'b1; end
        end else cnt = cnt - s;
      end
    end
`ifdef COUNT_OVF_STICKY_EN
    if (b) o = 1'b1;
    else if (clr_ovf) o = 1'b0;
`else
    o = 1'b0;
`endif
  endtask

  task automatic check_outputs();
    chk("out8", 32'(out8), 32'(c8));
    chk("wrap8", 32'(wrap8), 32'(w8));
    chk("tc8", 32'(tc8), up_down ? 32'(c8 == 255) : 32'(c8 == 0));
    chk("ovf8", 32'(ovf8), 32'(o8));
    chk("out9", 32'(out9), 32'(c9));
    chk("wrap9", 32'(wrap9), 32'(w9));
    chk("tc9", 32'(tc9), up_down ? 32'(c9 == 9) : 32'(c9 == 0));
    chk("ovf9", 32'(ovf9), 32'(o9));
  endtask

  // Called at posedge+1: drive inputs, check before the edge, then advance the model on the edge.
  task automatic do_cycle(input bit e, input bit l, input bit ud, input bit sat, input bit clr,
                          input int s, input int v8, input int v9);
    en = e; load = l; up_down = ud; sat_mode = sat; clr_ovf = clr;
    stp8 = 4'(s); lv8 = 8'(v8); lv9 = 4'(v9);
    #2;
    check_outputs();
    @(posedge clk);
    model_step(255, s, v8, c8, w8, o8);
    model_step(9, s & 7, v9, c9, w9, o9);
    #1;
  endtask

  task automatic model_reset();
    c8 = 0; c9 = 0; w8 = 0; w9 = 0; o8 = 0; o9 = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; en = 1'b0; load = 1'b0; up_down = 1'b1; sat_mode = 1'b0; clr_ovf = 1'b0;
    lv8 = '0; lv9 = '0; stp8 = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    // full up-count run through one wrap
    for (int i = 0; i < 258; i++) do_cycle(1, 0, 1, 0, 0, 1, 0, 0);

    // up past the top: wrap then saturate
    do_cycle(0, 1, 1, 0, 0, 0, 2, 7);
    do_cycle(1, 0, 1, 0, 0, 4, 0, 0);
    chk("dec_wrap_out", 32'(out9), 32'd1);
    chk("dec_wrap_pulse", 32'(wrap9), 32'd1);
    do_cycle(0, 0, 1, 0, 0, 4, 0, 0);
    do_cycle(0, 1, 1, 1, 0, 0, 2, 7);
    do_cycle(1, 0, 1, 1, 0, 4, 0, 0);
    chk("dec_sat_out", 32'(out9), 32'd9);
    chk("dec_sat_tc", 32'(tc9), 32'd1);
    for (int i = 0; i < 10; i++) do_cycle(1, 0, 1, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 1, 0, 1, 0, 0, 0);

    // down past zero: wrap then saturate
    do_cycle(0, 1, 0, 0, 0, 0, 2, 2);
    do_cycle(1, 0, 0, 0, 0, 5, 0, 0);
    chk("dn_wrap_out", 32'(out8), 32'd253);
    chk("dn_wrap_pulse", 32'(wrap8), 32'd1);
    do_cycle(0, 1, 0, 1, 0, 0, 2, 2);
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 0, 1, 0, 5, 0, 0);
    chk("dn_sat_out", 32'(out8), 32'd0);

    // priority and hold cases; load above the modulus clamps on the decade counter
    do_cycle(1, 1, 1, 0, 0, 3, 100, 15);
    do_cycle(0, 0, 1, 0, 0, 3, 0, 0);
    do_cycle(1, 0, 1, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 1, 1, 0, 0, 0, 254, 8);
    // wrap on the same edge as a clear
    do_cycle(1, 0, 1, 0, 1, 3, 0, 0);

    // asynchronous reset while a wrap pulse is pending
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out8", 32'(out8), 32'd0);
    chk("arst_wrap8", 32'(wrap8), 32'd0);
    chk("arst_out9", 32'(out9), 32'd0);
    chk("arst_ovf8", 32'(ovf8), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 1, 0, 0, 1, 0, 0);

    // randomised traffic
    for (int i = 0; i < 2000; i++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
    end
    #2;
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
